// File: rtl/dcache_write_interface_if.sv
// Handshake and dcache write-port bundle for dcache_write_interface.
// master = the write interface block, slave = pipeline/dcache environment.
interface dcache_write_interface_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                      a_valid;
  logic                      a_ready;
  logic                      e_valid;
  logic                      e_ready;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [DATA_WIDTH/8-1:0]   store_mask;
  logic [ADDR_WIDTH-1:0]     op0_address;
  logic                      op0_address_is_valid;
  logic [ADDR_WIDTH-1:0]     op1_address;
  logic                      op1_address_is_valid;
  logic                      wr_req_valid;
  logic                      wr_req_ready;
  logic [ADDR_WIDTH-1:0]     wr_req_address;
  logic [DATA_WIDTH-1:0]     wr_req_data;
  logic [DATA_WIDTH/8-1:0]   wr_req_mask;
  logic                      wr_ack_valid;
  logic                      wr_ack_ready;

  modport master (
    input  a_valid, e_ready, store_data, store_mask,
    input  op0_address, op0_address_is_valid, op1_address, op1_address_is_valid,
    input  wr_req_ready, wr_ack_valid,
    output a_ready, e_valid, wr_req_valid, wr_req_address, wr_req_data, wr_req_mask,
    output wr_ack_ready
  );

  modport slave (
    output a_valid, e_ready, store_data, store_mask,
    output op0_address, op0_address_is_valid, op1_address, op1_address_is_valid,
    output wr_req_ready, wr_ack_valid,
    input  a_ready, e_valid, wr_req_valid, wr_req_address, wr_req_data, wr_req_mask,
    input  wr_ack_ready
  );
endinterface

// File: rtl/dcache_write_interface.sv
// Writeback-stage store engine: captures one instruction and issues up to two
// dcache writes (op0 then op1), each waiting for its acknowledge.
module dcache_write_interface #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  dcache_write_interface_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    ACK0 = 3'd2,
    REQ1 = 3'd3,
    ACK1 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [DATA_WIDTH/8-1:0] cap_mask;
  logic [ADDR_WIDTH-1:0]   cap_op0_addr;
  logic [ADDR_WIDTH-1:0]   cap_op1_addr;
  logic                    cap_op0_vld;
  logic                    cap_op1_vld;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    a_ready_r;
  logic                    e_valid_r;
  logic                    req_valid_r;
  logic                    ack_ready_r;

  // All handshake outputs are registered alongside the state so no input
  // reaches an output within the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_ready_r    <= 1'b1;
      e_valid_r    <= 1'b0;
      req_valid_r  <= 1'b0;
      ack_ready_r  <= 1'b0;
      req_addr     <= '0;
      cap_data     <= '0;
      cap_mask     <= '0;
      cap_op0_addr <= '0;
      cap_op1_addr <= '0;
      cap_op0_vld  <= 1'b0;
      cap_op1_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_valid) begin
            cap_data     <= bus.store_data;
            cap_mask     <= bus.store_mask;
            cap_op0_addr <= bus.op0_address;
            cap_op1_addr <= bus.op1_address;
            cap_op0_vld  <= bus.op0_address_is_valid;
            cap_op1_vld  <= bus.op1_address_is_valid;
            a_ready_r    <= 1'b0;
            if (bus.op0_address_is_valid) begin
              state       <= REQ0;
              req_valid_r <= 1'b1;
              req_addr    <= bus.op0_address;
            end else if (bus.op1_address_is_valid) begin
              state       <= REQ1;
              req_valid_r <= 1'b1;
              req_addr    <= bus.op1_address;
            end else begin
              state     <= DONE;
              e_valid_r <= 1'b1;
            end
          end
        end
        REQ0: begin
          if (bus.wr_req_ready) begin
            state       <= ACK0;
            req_valid_r <= 1'b0;
            ack_ready_r <= 1'b1;
          end
        end
        ACK0: begin
          if (bus.wr_ack_valid) begin
            ack_ready_r <= 1'b0;
            if (cap_op1_vld) begin
              state       <= REQ1;
              req_valid_r <= 1'b1;
              req_addr    <= cap_op1_addr;
            end else begin
              state     <= DONE;
              e_valid_r <= 1'b1;
            end
          end
        end
        REQ1: begin
          if (bus.wr_req_ready) begin
            state       <= ACK1;
            req_valid_r <= 1'b0;
            ack_ready_r <= 1'b1;
          end
        end
        ACK1: begin
          if (bus.wr_ack_valid) begin
            state       <= DONE;
            ack_ready_r <= 1'b0;
            e_valid_r   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.e_ready) begin
            state     <= IDLE;
            e_valid_r <= 1'b0;
            a_ready_r <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          a_ready_r   <= 1'b1;
          e_valid_r   <= 1'b0;
          req_valid_r <= 1'b0;
          ack_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready        = a_ready_r;
  assign bus.e_valid        = e_valid_r;
  assign bus.wr_req_valid   = req_valid_r;
  assign bus.wr_req_address = req_addr;
  assign bus.wr_req_data    = cap_data;
  assign bus.wr_req_mask    = cap_mask;
  assign bus.wr_ack_ready   = ack_ready_r;

endmodule
